dma_peripheral: RTL and testbench



---
 rtl/dma_peripheral.sv | 169 ++++++++++++++++
 tb/tb_dma_peripheral.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_peripheral.sv
// Block-copy DMA engine and main-bus arbiter: muxes core traffic onto the bus and
// steals cycles (stalling the core) to copy LEN words from SRC to DST.
module dma_peripheral #(
  parameter logic [15:0] BASE_ADDR = 16'h8500,
  parameter int unsigned GAP       = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] core_read_addr,
  input  logic [15:0] core_write_addr,
  input  logic [15:0] core_write_data,
  input  logic        core_write_strobe,
  output logic        core_stall,
  output logic [15:0] read_addr,
  output logic [15:0] write_addr,
  output logic [15:0] write_data,
  output logic        write_strobe,
  input  logic [15:0] bus_read_data,
  output logic [15:0] dma_read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_GAP
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP);

  state_t      r_state;
  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic [15:0] r_len;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_gap_cnt;
  logic [15:0] r_rdata;

  logic        w_core_owns;
  logic [15:0] w_woff;
  logic [15:0] w_roff;
  logic        w_whit;
  logic        w_rhit;
  logic        w_reg_we;
  logic        w_ctrl_we;
  logic [15:0] w_len_next;
  logic [15:0] w_rsel;

  assign w_core_owns = (r_state == S_IDLE) || (r_state == S_GAP);

  // Offset arithmetic wraps, so addresses below BASE_ADDR fall far out of range.
  assign w_woff     = core_write_addr - BASE_ADDR;
  assign w_roff     = core_read_addr - BASE_ADDR;
  assign w_whit     = (w_woff < 16'd4);
  assign w_rhit     = (w_roff < 16'd4);
  assign w_reg_we   = core_write_strobe && w_core_owns && w_whit;
  assign w_ctrl_we  = w_reg_we && (w_woff[1:0] == 2'd3);
  assign w_len_next = r_len - 16'd1;

  always_comb begin
    w_rsel = '0;
    case (w_roff[1:0])
      2'd0:    w_rsel = r_src;
      2'd1:    w_rsel = r_dst;
      2'd2:    w_rsel = r_len;
      default: w_rsel = {14'd0, r_done, r_busy};
    endcase
  end

  always_comb begin
    read_addr    = core_read_addr;
    write_addr   = core_write_addr;
    write_data   = core_write_data;
    write_strobe = core_write_strobe;
    core_stall   = 1'b0;
    case (r_state)
      S_RD: begin
        read_addr    = r_src;
        write_strobe = 1'b0;
        core_stall   = 1'b1;
      end
      S_WR: begin
        read_addr    = r_src;
        write_addr   = r_dst;
        write_data   = bus_read_data;
        write_strobe = 1'b1;
        core_stall   = 1'b1;
      end
      default: ;
    endcase
  end

  assign dma_read_data = r_rdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_gap_cnt <= '0;
      r_rdata   <= '0;
    end else begin
      r_rdata <= (w_core_owns && w_rhit) ? w_rsel : '0;

      case (r_state)
        S_IDLE: begin
          if (w_reg_we) begin
            case (w_woff[1:0])
              2'd0: r_src <= core_write_data;
              2'd1: r_dst <= core_write_data;
              2'd2: r_len <= core_write_data;
              default: begin
                // Start takes precedence over a simultaneous done-clear.
                if (core_write_data[0]) begin
                  if (r_len == 16'd0) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                  end else begin
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                    r_state <= S_RD;
                  end
                end else if (core_write_data[1]) begin
                  r_done <= 1'b0;
                end
              end
            endcase
          end
        end

        S_RD: r_state <= S_WR;

        S_WR: begin
          r_src <= r_src + 16'd1;
          r_dst <= r_dst + 16'd1;
          r_len <= w_len_next;
          if (w_len_next == 16'd0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state   <= S_GAP;
            r_gap_cnt <= GAP_LOAD;
          end
        end

        default: begin
          if (w_ctrl_we && core_write_data[1]) begin
            r_done <= 1'b0;
          end
          if (w_ctrl_we && core_write_data[2]) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (r_gap_cnt <= 4'd1) begin
            r_state <= S_RD;
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_peripheral.sv
// Directed bench for dma_peripheral: two instances (GAP=1 and GAP=3), each with its own RAM model.
module tb_dma_peripheral;

  localparam logic [15:0] A_SRC  = 16'h8500;
  localparam logic [15:0] A_DST  = 16'h8501;
  localparam logic [15:0] A_LEN  = 16'h8502;
  localparam logic [15:0] A_CTRL = 16'h8503;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] c_raddr [2];
  logic [15:0] c_waddr [2];
  logic [15:0] c_wdata [2];
  logic        c_wstb  [2];
  logic        stall   [2];
  logic [15:0] raddr   [2];
  logic [15:0] waddr   [2];
  logic [15:0] wdata   [2];
  logic        wstb    [2];
  logic [15:0] bus_rd  [2];
  logic [15:0] dma_rd  [2];
  logic [15:0] ram_rd  [2];
  logic [15:0] mem     [2][65536];
  int          n_stall [2] = '{0, 0};
  int          n_dwr   [2] = '{0, 0};
  int          n_chk   = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign bus_rd[0] = ram_rd[0] | dma_rd[0];
  assign bus_rd[1] = ram_rd[1] | dma_rd[1];

  dma_peripheral #(.BASE_ADDR(16'h8500), .GAP(1)) u_dut_g1 (
    .i_clk(clk), .i_rst(rst),
    .core_read_addr(c_raddr[0]), .core_write_addr(c_waddr[0]),
    .core_write_data(c_wdata[0]), .core_write_strobe(c_wstb[0]),
    .core_stall(stall[0]), .read_addr(raddr[0]), .write_addr(waddr[0]),
    .write_data(wdata[0]), .write_strobe(wstb[0]),
    .bus_read_data(bus_rd[0]), .dma_read_data(dma_rd[0])
  );

  dma_peripheral #(.BASE_ADDR(16'h8500), .GAP(3)) u_dut_g3 (
    .i_clk(clk), .i_rst(rst),
    .core_read_addr(c_raddr[1]), .core_write_addr(c_waddr[1]),
    .core_write_data(c_wdata[1]), .core_write_strobe(c_wstb[1]),
    .core_stall(stall[1]), .read_addr(raddr[1]), .write_addr(waddr[1]),
    .write_data(wdata[1]), .write_strobe(wstb[1]),
    .bus_read_data(bus_rd[1]), .dma_read_data(dma_rd[1])
  );

  // RAM model: registered read, zero while the DMA register window is addressed.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      ram_rd[d] <= (raddr[d] >= A_SRC && raddr[d] <= A_CTRL) ? 16'h0000 : mem[d][raddr[d]];
      if (wstb[d]) mem[d][waddr[d]] <= wdata[d];
      if (stall[d]) n_stall[d] <= n_stall[d] + 1;
      if (stall[d] && wstb[d]) n_dwr[d] <= n_dwr[d] + 1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cwrite(input int d, input logic [15:0] a, input logic [15:0] v);
    c_waddr[d] = a;
    c_wdata[d] = v;
    c_wstb[d]  = 1'b1;
    tick();
    c_wstb[d]  = 1'b0;
  endtask

  task automatic rchk(input int d, input logic [15:0] a, input logic [15:0] exp, input string tag);
    c_raddr[d] = a;
    tick();
    chk(tag, bus_rd[d], exp);
  endtask

  int s0, w0;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      c_raddr[d] = '0; c_waddr[d] = '0; c_wdata[d] = '0; c_wstb[d] = 1'b0;
    end
    c_raddr[0] = 16'h1234;
    c_waddr[0] = 16'h0200;
    c_wdata[0] = 16'h0777;
    #12;
    chk("rst_stall", {15'd0, stall[0]}, 16'h0000);
    chk("rst_dma_rd", dma_rd[0], 16'h0000);
    chk("rst_raddr_mirror", raddr[0], 16'h1234);
    chk("rst_wdata_mirror", wdata[0], 16'h0777);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    c_raddr[0] = '0;

    // Three-word copy, GAP=1
    cwrite(0, 16'h0010, 16'h00A1);
    cwrite(0, 16'h0011, 16'h00B2);
    cwrite(0, 16'h0012, 16'h00C3);
    cwrite(0, A_SRC, 16'h0010);
    cwrite(0, A_DST, 16'h0040);
    cwrite(0, A_LEN, 16'h0003);
    s0 = n_stall[0]; w0 = n_dwr[0];
    cwrite(0, A_CTRL, 16'h0001);
    chk("cp_rd_stall", {15'd0, stall[0]}, 16'h0001);
    chk("cp_rd_addr", raddr[0], 16'h0010);
    tick();
    chk("cp_wr_strobe", {15'd0, wstb[0]}, 16'h0001);
    chk("cp_wr_addr", waddr[0], 16'h0040);
    chk("cp_wr_data", wdata[0], 16'h00A1);
    tick();
    chk("cp_gap_stall", {15'd0, stall[0]}, 16'h0000);
    repeat (5) tick();
    chk("cp_last_wr_data", wdata[0], 16'h00C3);
    tick();
    chk("cp_end_stall", {15'd0, stall[0]}, 16'h0000);
    chk("cp_stall_cycles", 16'(n_stall[0] - s0), 16'd6);
    chk("cp_dma_writes", 16'(n_dwr[0] - w0), 16'd3);
    rchk(0, A_CTRL, 16'h0002, "cp_status");
    rchk(0, 16'h0040, 16'h00A1, "cp_mem40");
    rchk(0, 16'h0041, 16'h00B2, "cp_mem41");
    rchk(0, 16'h0042, 16'h00C3, "cp_mem42");
    rchk(0, A_SRC, 16'h0013, "cp_src_final");
    rchk(0, A_DST, 16'h0043, "cp_dst_final");
    rchk(0, A_LEN, 16'h0000, "cp_len_final");

    // LEN=0 start completes immediately
    cwrite(0, A_CTRL, 16'h0002);
    c_raddr[0] = A_CTRL;
    tick();
    chk("z_done_cleared", dma_rd[0], 16'h0000);
    s0 = n_stall[0]; w0 = n_dwr[0];
    cwrite(0, A_CTRL, 16'h0001);
    chk("z_no_stall", {15'd0, stall[0]}, 16'h0000);
    tick();
    chk("z_status", dma_rd[0], 16'h0002);
    chk("z_stall_cycles", 16'(n_stall[0] - s0), 16'd0);
    chk("z_dma_writes", 16'(n_dwr[0] - w0), 16'd0);

    // Source address wraps at 16'hFFFF
    cwrite(0, 16'hFFFF, 16'h1111);
    cwrite(0, 16'h0000, 16'h2222);
    cwrite(0, A_SRC, 16'hFFFF);
    cwrite(0, A_DST, 16'h0080);
    cwrite(0, A_LEN, 16'h0002);
    cwrite(0, A_CTRL, 16'h0001);
    chk("wrap_rd1_addr", raddr[0], 16'hFFFF);
    repeat (3) tick();
    chk("wrap_rd2_addr", raddr[0], 16'h0000);
    tick();
    chk("wrap_wr2_addr", waddr[0], 16'h0081);
    chk("wrap_wr2_data", wdata[0], 16'h2222);
    tick();
    rchk(0, A_SRC, 16'h0001, "wrap_src_final");
    rchk(0, 16'h0080, 16'h1111, "wrap_mem80");
    rchk(0, 16'h0081, 16'h2222, "wrap_mem81");

    // GAP=3: SRC write during GAP ignored, abort in second GAP
    cwrite(1, 16'h0020, 16'h0A0A);
    cwrite(1, 16'h0021, 16'h0B0B);
    cwrite(1, 16'h0022, 16'h0C0C);
    cwrite(1, 16'h0023, 16'h0D0D);
    cwrite(1, 16'h0062, 16'hDEAD);
    cwrite(1, A_SRC, 16'h0020);
    cwrite(1, A_DST, 16'h0060);
    cwrite(1, A_LEN, 16'h0004);
    w0 = n_dwr[1];
    cwrite(1, A_CTRL, 16'h0001);
    repeat (2) tick();
    chk("ab_gap1_stall", {15'd0, stall[1]}, 16'h0000);
    cwrite(1, A_SRC, 16'h1234);
    repeat (4) tick();
    chk("ab_gap2_stall", {15'd0, stall[1]}, 16'h0000);
    cwrite(1, A_CTRL, 16'h0004);
    repeat (2) tick();
    chk("ab_idle_stall", {15'd0, stall[1]}, 16'h0000);
    rchk(1, A_CTRL, 16'h0000, "ab_status");
    rchk(1, A_SRC, 16'h0022, "ab_src");
    rchk(1, A_LEN, 16'h0002, "ab_len");
    rchk(1, 16'h0060, 16'h0A0A, "ab_mem60");
    rchk(1, 16'h0061, 16'h0B0B, "ab_mem61");
    rchk(1, 16'h0062, 16'hDEAD, "ab_mem62");
    chk("ab_dma_writes", 16'(n_dwr[1] - w0), 16'd2);

    // Core strobe held through RD/WR is masked
    cwrite(1, 16'h0030, 16'hBEEF);
    cwrite(1, A_SRC, 16'h0030);
    cwrite(1, A_DST, 16'h0070);
    cwrite(1, A_LEN, 16'h0001);
    cwrite(1, A_CTRL, 16'h0001);
    c_waddr[1] = 16'h0090;
    c_wdata[1] = 16'h5555;
    c_wstb[1]  = 1'b1;
    #1;
    chk("mask_rd_strobe", {15'd0, wstb[1]}, 16'h0000);
    tick();
    chk("mask_wr_addr", waddr[1], 16'h0070);
    chk("mask_wr_data", wdata[1], 16'hBEEF);
    tick();
    chk("mask_idle_strobe", {15'd0, wstb[1]}, 16'h0001);
    chk("mask_idle_addr", waddr[1], 16'h0090);
    chk("mask_idle_data", wdata[1], 16'h5555);
    tick();
    c_wstb[1] = 1'b0;
    rchk(1, 16'h0070, 16'hBEEF, "mask_mem70");
    rchk(1, 16'h0090, 16'h5555, "mask_mem90");
    rchk(1, A_CTRL, 16'h0002, "mask_status");

    // Reset asserted mid-WR
    cwrite(0, A_SRC, 16'h0010);
    cwrite(0, A_DST, 16'h0050);
    cwrite(0, A_LEN, 16'h0003);
    cwrite(0, A_CTRL, 16'h0001);
    tick();
    chk("rr_wr_strobe", {15'd0, wstb[0]}, 16'h0001);
    c_waddr[0] = 16'h0100;
    c_wstb[0]  = 1'b0;
    rst = 1'b1;
    #1;
    chk("rr_strobe_drop", {15'd0, wstb[0]}, 16'h0000);
    chk("rr_stall", {15'd0, stall[0]}, 16'h0000);
    c_wstb[0] = 1'b1;
    #1;
    chk("rr_strobe_follow", {15'd0, wstb[0]}, 16'h0001);
    c_wstb[0] = 1'b0;
    tick();
    rst = 1'b0;
    rchk(0, A_SRC, 16'h0000, "rr_src");
    rchk(0, A_DST, 16'h0000, "rr_dst");
    rchk(0, A_LEN, 16'h0000, "rr_len");
    rchk(0, A_CTRL, 16'h0000, "rr_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
